z80_bus_monitor: RTL
====================

# z80_bus_monitor

Passive bus-cycle recorder that sits directly downstream of the tv80s CPU, alongside the bench memory/IO model, and consumes the same CPU bus pins. It classifies every machine cycle (opcode fetch, memory read/write, IO read/write, interrupt acknowledge, optional refresh) and captures address, data and a start timestamp. Completed records go into a first-word-fall-through FIFO that a checker drains through a valid/ready handshake. Instruction-level benches use it to assert exact bus traffic, not only final register and memory state.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `TS_W`, 16: timestamp counter width.
- `clk` in 1: CPU clock, rising-edge active.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, new cycles may start being recorded.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n` in 1 each: CPU bus strobes.
- `A` in 16: CPU address bus.
- `di` in 8: data driven into the CPU.
- `dout` in 8: data driven by the CPU.
- `rec_valid` out 1: head record is available.
- `rec_ready` in 1: consumer accepts the head record.
- `rec_type` out 3: cycle type of the head record.
- `rec_addr` out 16: address of the head record.
- `rec_data` out 8: data of the head record.
- `rec_ts` out `TS_W`: start timestamp of the head record.
- `level` out log2(DEPTH)+1: number of records in the FIFO.
- `drop_cnt` out 8: records lost to overflow; saturates at 255.

## Operation
- Stage S1 registers all bus inputs on every rising edge. All decoding uses S1 values only.
- Type codes, first match wins:
  - 5 INTACK: m1 and iorq low.
  - 0 FETCH: m1, mreq and rd low.
  - 6 RFSH: rfsh and mreq low.
  - 1 MEMRD: mreq and rd low.
  - 2 MEMWR: mreq and wr low.
  - 3 IORD: iorq and rd low.
  - 4 IOWR: iorq and wr low.
  - 7 is never produced.
- FSM states:
  - IDLE: when `enable` is high and S1 matches a type, latch the type, address and current timestamp, then go to ACTIVE.
  - ACTIVE: each edge where the latched type's strobes are still active in S1, latch data. MEMWR and IOWR take `dout`; all other types take `di`. Address is latched only on entry. When S1 shows the strobes inactive, go to PUSH.
  - PUSH: write one record to the FIFO and return to IDLE. A new cycle can be detected in this same clock.
- Dropping `enable` while in ACTIVE does not abort the cycle; it completes normally.
- Type change while in ACTIVE (e.g. FETCH followed directly by RFSH with no idle clock): the current record is pushed, then the new type starts.
- Timestamp: free-running `TS_W`-bit counter, cleared by reset, increments every clock, wraps to 0.
- FIFO:
  - A push while full is dropped unless a pop occurs in the same clock, in which case the push is accepted.
  - A pop happens when `rec_valid` and `rec_ready` are both high.
  - Pop while empty is ignored.
  - Simultaneous push and pop on an empty FIFO: the record is written, `rec_valid` goes high the next clock.
- `drop_cnt` increments once per dropped record and holds at 255.

## Timing
- All outputs reset to 0: `rec_valid`, `rec_type`, `rec_addr`, `rec_data`, `rec_ts`, `level`, `drop_cnt`. FSM resets to IDLE; the timestamp counter and FIFO pointers clear.
- Reset mid-cycle discards the in-flight record with no push.
- Edge E is the first rising edge at which the CPU strobe is sampled inactive. The FSM pushes at E+1, and `rec_valid`/`level` update after E+1.
- `rec_data` is the last value sampled at or before E-1.
- `rec_ts` is the counter value at the edge where S1 first showed the strobe active.
- Head outputs change only after a pop or a push-into-empty.
- `rec_valid` never drops without a pop.

## Configuration
- `Z80_BUS_MONITOR_RFSH_EN` defined: RFSH cycles are recorded as type 6, with the refresh address and `di`.
- Undefined: RFSH-matching S1 states are treated as idle. No record is produced and no timestamp is latched. FIFO traffic then consists only of types 0-5.

## Test plan
- Reset behaviour: hold `reset_n` low, then release. All outputs read 0. Assert `reset_n` low mid-MEMRD: no record appears and `level` stays 0.
- CPU run with a reset release at 30 ns:
  - Setup: PC=0000, IX=EEF5, L=B5; memory 0000..0003 = DD CB 49 AD, EF3E = 76.
  - Required records: first is FETCH/0000/DD. Last two are MEMRD/EF3E/76 then MEMWR/EF3E/56. All timestamps strictly increase.
- Overflow with DEPTH=4 and `rec_ready`=0: drive 6 MEMWR cycles. `level`=4 and `drop_cnt`=2. Drained records are the first four, in order.
- Full with simultaneous pop: with the FIFO full, pulse `rec_ready` in the push clock. `level` stays 4 and `drop_cnt` is unchanged.
- Enable gating: drop `enable` mid-IOWR to port 0x5A with data 0x3C. The IOWR record still appears. The next IORD is not recorded.
- Refresh: FETCH followed directly by RFSH at 0x0041. With `Z80_BUS_MONITOR_RFSH_EN` defined, two records (types 0 and 6). Without it, one record (type 0).

Source files
------------

// File: rtl/z80_bus_monitor.sv
// z80_bus_monitor: passive tv80 bus-cycle recorder feeding a first-word-fall-through record FIFO.
// Define Z80_BUS_MONITOR_RFSH_EN to record refresh cycles as type 6; otherwise refresh is treated as idle.
module z80_bus_monitor #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TS_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   m1_n,
   input  logic                   mreq_n,
   input  logic                   iorq_n,
   input  logic                   rd_n,
   input  logic                   wr_n,
   input  logic                   rfsh_n,
   input  logic [15:0]            A,
   input  logic [7:0]             di,
   input  logic [7:0]             dout,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [2:0]             rec_type,
   output logic [15:0]            rec_addr,
   output logic [7:0]             rec_data,
   output logic [TS_W-1:0]        rec_ts,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic [2:0] T_FETCH  = 3'd0;
   localparam logic [2:0] T_MEMRD  = 3'd1;
   localparam logic [2:0] T_MEMWR  = 3'd2;
   localparam logic [2:0] T_IORD   = 3'd3;
   localparam logic [2:0] T_IOWR   = 3'd4;
   localparam logic [2:0] T_INTACK = 3'd5;
`ifdef Z80_BUS_MONITOR_RFSH_EN
   localparam logic [2:0] T_RFSH   = 3'd6;
`endif

   typedef struct packed {
      logic [2:0]      typ;
      logic [15:0]     addr;
      logic [7:0]      data;
      logic [TS_W-1:0] ts;
   } rec_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_PUSH   = 2'd2
   } state_t;

   // S1: registered copy of every bus input; all decoding looks only at these
   logic        s1_m1_n, s1_mreq_n, s1_iorq_n, s1_rd_n, s1_wr_n, s1_rfsh_n;
   logic [15:0] s1_a;
   logic [7:0]  s1_di, s1_dout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_m1_n   <= 1'b1;
         s1_mreq_n <= 1'b1;
         s1_iorq_n <= 1'b1;
         s1_rd_n   <= 1'b1;
         s1_wr_n   <= 1'b1;
         s1_rfsh_n <= 1'b1;
         s1_a      <= '0;
         s1_di     <= '0;
         s1_dout   <= '0;
      end else begin
         s1_m1_n   <= m1_n;
         s1_mreq_n <= mreq_n;
         s1_iorq_n <= iorq_n;
         s1_rd_n   <= rd_n;
         s1_wr_n   <= wr_n;
         s1_rfsh_n <= rfsh_n;
         s1_a      <= A;
         s1_di     <= di;
         s1_dout   <= dout;
      end
   end

   // Cycle classification, first match wins
   logic       dec_hit_c;
   logic [2:0] dec_type_c;
   logic [7:0] dec_data_c;

   always_comb begin
      dec_hit_c  = 1'b1;
      dec_type_c = T_FETCH;
      if (!s1_m1_n && !s1_iorq_n) begin
         dec_type_c = T_INTACK;
      end else if (!s1_m1_n && !s1_mreq_n && !s1_rd_n) begin
         dec_type_c = T_FETCH;
      end else if (!s1_rfsh_n && !s1_mreq_n) begin
`ifdef Z80_BUS_MONITOR_RFSH_EN
         dec_type_c = T_RFSH;
`else
         dec_hit_c  = 1'b0;
`endif
      end else if (!s1_mreq_n && !s1_rd_n) begin
         dec_type_c = T_MEMRD;
      end else if (!s1_mreq_n && !s1_wr_n) begin
         dec_type_c = T_MEMWR;
      end else if (!s1_iorq_n && !s1_rd_n) begin
         dec_type_c = T_IORD;
      end else if (!s1_iorq_n && !s1_wr_n) begin
         dec_type_c = T_IOWR;
      end else begin
         dec_hit_c  = 1'b0;
      end
      dec_data_c = ((dec_type_c == T_MEMWR) || (dec_type_c == T_IOWR)) ? s1_dout : s1_di;
   end

   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_cnt <= '0;
      else          ts_cnt <= ts_cnt + TS_W'(1);
   end

   state_t state, state_nxt;
   rec_t   cur;
   logic   still_active_c;
   logic   start_c, capture_c, push_c;

   // A type change counts as the latched cycle ending
   assign still_active_c = dec_hit_c && (dec_type_c == cur.typ);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (enable && dec_hit_c) state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (!still_active_c)     state_nxt = ST_PUSH;
         ST_PUSH:   state_nxt = (enable && dec_hit_c) ? ST_ACTIVE : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      start_c   = 1'b0;
      capture_c = 1'b0;
      push_c    = 1'b0;
      case (state)
         ST_IDLE:   start_c   = enable && dec_hit_c;
         ST_ACTIVE: capture_c = still_active_c;
         ST_PUSH: begin
            push_c  = 1'b1;
            start_c = enable && dec_hit_c;
         end
         default: ;
      endcase
   end

   // In-flight record; address and timestamp only on entry, data on every active edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur <= '0;
      end else if (start_c) begin
         cur.typ  <= dec_type_c;
         cur.addr <= s1_a;
         cur.data <= dec_data_c;
         cur.ts   <= ts_cnt;
      end else if (capture_c) begin
         cur.data <= dec_data_c;
      end
   end

   rec_t           mem [DEPTH];
   rec_t           head, head_nxt;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level_nxt;
   logic           pop_c, full_c, push_ok_c;

   assign pop_c     = rec_valid && rec_ready;
   assign full_c    = (level == LW'(DEPTH));
   assign push_ok_c = push_c && (!full_c || pop_c);
   assign level_nxt = level + LW'(push_ok_c) - LW'(pop_c);

   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_ptr] <= cur;
   end

   // Head register: reload only on a pop or when the FIFO goes from empty to non-empty
   always_comb begin
      head_nxt = head;
      if (pop_c && (level_nxt != '0)) begin
         head_nxt = (level == LW'(1)) ? cur : mem[rd_ptr + AW'(1)];
      end else if (!rec_valid && push_ok_c) begin
         head_nxt = cur;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         rec_valid <= 1'b0;
         head      <= '0;
         drop_cnt  <= '0;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
         level     <= level_nxt;
         rec_valid <= (level_nxt != '0);
         head      <= head_nxt;
         if (push_c && !push_ok_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign rec_type = head.typ;
   assign rec_addr = head.addr;
   assign rec_data = head.data;
   assign rec_ts   = head.ts;

endmodule
